// File: rtl/riscv_32im_pkg.sv
// riscv_32im_pkg: shared owner type and outstanding-depth default for the memory arbiter
package riscv_32im_pkg;
  typedef enum logic {OWN_IFU = 1'b0, OWN_LSU = 1'b1} T_MEM_OWNER;
  localparam int MAX_OUTSTANDING_DEFAULT = 2;
endpackage

// File: rtl/mem_owner_fifo.sv
// mem_owner_fifo: in-order {owner, kill} queue with broadcast kill of IFU entries
module mem_owner_fifo
  import riscv_32im_pkg::*;
#(
  parameter int DEPTH = MAX_OUTSTANDING_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  T_MEM_OWNER owner_i,
  input  logic       kill_i,
  input  logic       pop_i,
  output logic       empty_o,
  output logic       full_o,
  output T_MEM_OWNER owner_o,
  output logic       kill_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  T_MEM_OWNER       r_owner [DEPTH];
  logic [DEPTH-1:0] r_kill;
  logic [PW-1:0]    r_rd, r_wr;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    empty_o = r_count == '0;
    full_o  = r_count == CW'(DEPTH);
    w_push  = push_i && !full_o;
    w_pop   = pop_i && !empty_o;
    owner_o = r_owner[r_rd];
    // a flush in the same cycle as the pop still kills that response
    kill_o  = r_kill[r_rd] || (kill_i && r_owner[r_rd] == OWN_IFU);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_kill  <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++)
        if (kill_i && r_owner[k] == OWN_IFU) r_kill[k] <= 1'b1;
      if (w_push) begin
        r_owner[r_wr] <= owner_i;
        r_kill[r_wr]  <= kill_i && owner_i == OWN_IFU;
        r_wr          <= nxt(r_wr);
      end
      if (w_pop) r_rd <= nxt(r_rd);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin IFU/LSU arbiter onto one memory port with in-order response routing
module mem_arbiter
  import riscv_32im_pkg::*;
#(
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        ifu_req_valid_i,
  output logic        ifu_req_ready_o,
  input  logic [31:0] ifu_req_addr_i,
  input  logic        lsu_req_valid_i,
  output logic        lsu_req_ready_o,
  input  logic [31:0] lsu_req_addr_i,
  input  logic        lsu_req_we_i,
  input  logic [31:0] lsu_req_wdata_i,
  input  logic [3:0]  lsu_req_be_i,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_req_addr_o,
  output logic        mem_req_we_o,
  output logic [31:0] mem_req_wdata_o,
  output logic [3:0]  mem_req_be_o,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rsp_rdata_i,
  output logic        ifu_rsp_valid_o,
  output logic [31:0] ifu_rsp_rdata_o,
  output logic        lsu_rsp_valid_o,
  output logic [31:0] lsu_rsp_rdata_o
);
  T_MEM_OWNER r_last_grant, r_lock_owner, w_owner, w_rsp_owner;
  logic       r_locked, w_full, w_empty, w_rsp_kill, w_own_valid, w_xfer, w_pop;
  always_comb begin
    // a stalled request keeps its owner so mem_req_* stays stable until accepted
    w_owner = r_locked ? r_lock_owner
            : (ifu_req_valid_i && lsu_req_valid_i) ? ((r_last_grant == OWN_IFU) ? OWN_LSU : OWN_IFU)
            : lsu_req_valid_i ? OWN_LSU : OWN_IFU;
    w_own_valid     = (w_owner == OWN_LSU) ? lsu_req_valid_i : ifu_req_valid_i;
    mem_req_valid_o = rst_ni && !w_full && w_own_valid;
    ifu_req_ready_o = rst_ni && !w_full && mem_req_ready_i && w_owner == OWN_IFU;
    lsu_req_ready_o = rst_ni && !w_full && mem_req_ready_i && w_owner == OWN_LSU;
    mem_req_addr_o  = !rst_ni ? '0 : (w_owner == OWN_LSU) ? lsu_req_addr_i : ifu_req_addr_i;
    mem_req_we_o    = rst_ni && w_owner == OWN_LSU && lsu_req_we_i;
    mem_req_wdata_o = (rst_ni && w_owner == OWN_LSU) ? lsu_req_wdata_i : '0;
    mem_req_be_o    = !rst_ni ? '0 : (w_owner == OWN_LSU) ? lsu_req_be_i : 4'hF;
    w_xfer          = mem_req_valid_o && mem_req_ready_i;
    w_pop           = rst_ni && mem_rsp_valid_i && !w_empty;
    lsu_rsp_valid_o = w_pop && w_rsp_owner == OWN_LSU;
    ifu_rsp_valid_o = w_pop && w_rsp_owner == OWN_IFU && !w_rsp_kill;
    ifu_rsp_rdata_o = ifu_rsp_valid_o ? mem_rsp_rdata_i : '0;
    lsu_rsp_rdata_o = lsu_rsp_valid_o ? mem_rsp_rdata_i : '0;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_last_grant <= OWN_IFU;
      r_lock_owner <= OWN_IFU;
      r_locked     <= 1'b0;
    end else begin
      if (w_xfer) r_last_grant <= w_owner;
      r_locked     <= mem_req_valid_o && !mem_req_ready_i;
      r_lock_owner <= w_owner;
    end
  end
  mem_owner_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_xfer),
    .owner_i (w_owner),
    .kill_i  (flush_i),
    .pop_i   (w_pop),
    .empty_o (w_empty),
    .full_o  (w_full),
    .owner_o (w_rsp_owner),
    .kill_o  (w_rsp_kill)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic against a queue-based reference model
module tb_mem_arbiter;
  localparam int MAXO = 2;
  logic        clk_i = 1'b0;
  logic        rst_ni, flush_i;
  logic        ifu_req_valid_i, ifu_req_ready_o;
  logic [31:0] ifu_req_addr_i;
  logic        lsu_req_valid_i, lsu_req_ready_o, lsu_req_we_i;
  logic [31:0] lsu_req_addr_i, lsu_req_wdata_i;
  logic [3:0]  lsu_req_be_i;
  logic        mem_req_valid_o, mem_req_ready_i, mem_req_we_o;
  logic [31:0] mem_req_addr_o, mem_req_wdata_o;
  logic [3:0]  mem_req_be_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_rdata_i;
  logic        ifu_rsp_valid_o, lsu_rsp_valid_o;
  logic [31:0] ifu_rsp_rdata_o, lsu_rsp_rdata_o;
  int n_tests = 0, n_fail = 0;
  logic [1:0]  model_q [$];
  logic [32:0] sb [$];
  bit rsp_popped = 0, m_last = 0, m_stalled = 0, m_stall_owner = 0, fire_i = 0, fire_l = 0;
  logic [31:0] rr_exp [4] = '{32'h2000, 32'h1000, 32'h2000, 32'h1000};

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o), .ifu_req_addr_i(ifu_req_addr_i),
    .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o), .lsu_req_addr_i(lsu_req_addr_i),
    .lsu_req_we_i(lsu_req_we_i), .lsu_req_wdata_i(lsu_req_wdata_i), .lsu_req_be_i(lsu_req_be_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_we_o(mem_req_we_o), .mem_req_wdata_o(mem_req_wdata_o), .mem_req_be_o(mem_req_be_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_rdata_i(mem_rsp_rdata_i),
    .ifu_rsp_valid_o(ifu_rsp_valid_o), .ifu_rsp_rdata_o(ifu_rsp_rdata_o),
    .lsu_rsp_valid_o(lsu_rsp_valid_o), .lsu_rsp_rdata_o(lsu_rsp_rdata_o)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model_q entry: bit0 owner (1 = LSU), bit1 killed; sb entry: {owner, rdata} of a visible response
  task automatic tick();
    logic [1:0] e;
    rsp_popped = 0;
    if (rst_ni) begin
      if (mem_rsp_valid_i && model_q.size() > 0) begin
        e = model_q.pop_front();
        rsp_popped = 1;
        if (e[0]) sb.push_back({1'b1, mem_rsp_rdata_i});
        else if (!e[1] && !flush_i) sb.push_back({1'b0, mem_rsp_rdata_i});
      end
      if (flush_i)
        for (int i = 0; i < model_q.size(); i++) if (!model_q[i][0]) model_q[i][1] = 1'b1;
    end
    @(negedge clk_i);
    fire_i = ifu_req_valid_i && ifu_req_ready_o;
    fire_l = lsu_req_valid_i && lsu_req_ready_o;
    @(posedge clk_i);
    #1;
    mem_rsp_valid_i = 0;
    flush_i = 0;
  endtask

  task automatic rsp(input logic [31:0] d);
    mem_rsp_valid_i = 1;
    mem_rsp_rdata_i = d;
  endtask

  task automatic set_lsu(input logic v, input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] be);
    lsu_req_valid_i = v;
    lsu_req_addr_i = a;
    lsu_req_we_i = we;
    lsu_req_wdata_i = wd;
    lsu_req_be_i = be;
  endtask

  // request-side reference: round robin on last completed grant, owner held while stalled, cap on outstanding
  always @(negedge clk_i) begin : req_model
    bit own, own_v, ev;
    int occ;
    if (!rst_ni) begin
      chk("rst_ctrl", {mem_req_valid_o, ifu_req_ready_o, lsu_req_ready_o, mem_req_we_o, mem_req_be_o,
                       ifu_rsp_valid_o, lsu_rsp_valid_o}, '0);
      chk("rst_data", {mem_req_addr_o, mem_req_wdata_o}, '0);
      model_q.delete();
      m_last = 0;
      m_stalled = 0;
    end else begin
      occ = model_q.size() + int'(rsp_popped);
      own = m_stalled ? m_stall_owner : (ifu_req_valid_i && lsu_req_valid_i) ? !m_last : lsu_req_valid_i;
      own_v = own ? lsu_req_valid_i : ifu_req_valid_i;
      ev = occ < MAXO && own_v;
      chk("mem_req_valid", mem_req_valid_o, ev);
      if (ev) begin
        chk("mem_req_fields", {mem_req_addr_o, mem_req_we_o, mem_req_wdata_o, mem_req_be_o},
            own ? {lsu_req_addr_i, lsu_req_we_i, lsu_req_wdata_i, lsu_req_be_i} : {ifu_req_addr_i, 1'b0, 32'h0, 4'hF});
        chk("req_ready", {ifu_req_ready_o, lsu_req_ready_o}, {!own && mem_req_ready_i, own && mem_req_ready_i});
      end else if (occ >= MAXO)
        chk("ready_full", {ifu_req_ready_o, lsu_req_ready_o}, 2'b00);
      if (ev && mem_req_ready_i) begin
        model_q.push_back({flush_i && !own, own});
        m_last = own;
      end
      m_stalled = ev && !mem_req_ready_i;
      m_stall_owner = own;
    end
  end

  always @(negedge clk_i) begin : rsp_monitor
    logic [32:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp", {ifu_rsp_valid_o, lsu_rsp_valid_o, ifu_rsp_rdata_o, lsu_rsp_rdata_o},
          e[32] ? {2'b01, 32'h0, e[31:0]} : {2'b10, e[31:0], 32'h0});
    end else
      chk("rsp_idle", {ifu_rsp_valid_o, lsu_rsp_valid_o, ifu_rsp_rdata_o, lsu_rsp_rdata_o}, '0);
  end

  initial begin
    rst_ni = 0; flush_i = 0; mem_req_ready_i = 0; mem_rsp_valid_i = 0; mem_rsp_rdata_i = 0;
    ifu_req_valid_i = 0; ifu_req_addr_i = 0;
    set_lsu(0, 0, 0, 0, 0);
    tick();
    ifu_req_valid_i = 1; ifu_req_addr_i = 32'h1000;
    set_lsu(1, 32'h2000, 0, 0, 4'hF);
    mem_req_ready_i = 1;
    rsp(32'h99);
    tick();
    rst_ni = 1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) rsp($urandom);
      #1 chk("rr_grant", mem_req_addr_o, rr_exp[k]);
      tick();
    end
    ifu_req_valid_i = 0; lsu_req_valid_i = 0;
    rsp($urandom);
    tick();
    ifu_req_valid_i = 1; ifu_req_addr_i = 32'h100; mem_req_ready_i = 0;
    #1 chk("stall_addr0", {mem_req_addr_o, ifu_req_ready_o}, {32'h100, 1'b0});
    tick();
    set_lsu(1, 32'h300, 0, 0, 4'hF);
    #1 chk("stall_addr1", mem_req_addr_o, 32'h100);
    tick();
    #1 chk("stall_addr2", mem_req_addr_o, 32'h100);
    tick();
    mem_req_ready_i = 1;
    #1 chk("stall_accept", {mem_req_addr_o, ifu_req_ready_o, lsu_req_ready_o}, {32'h100, 2'b10});
    tick();
    ifu_req_valid_i = 0;
    #1 chk("after_stall_lsu", {mem_req_addr_o, lsu_req_ready_o}, {32'h300, 1'b1});
    tick();
    lsu_req_valid_i = 0;
    ifu_req_valid_i = 1; ifu_req_addr_i = 32'h104;
    #1 chk("full_block", {mem_req_valid_o, ifu_req_ready_o}, 2'b00);
    tick();
    rsp(32'hAAAA0001);
    #1 chk("full_rsp_cycle", {mem_req_valid_o, ifu_req_ready_o, ifu_rsp_valid_o}, 3'b001);
    tick();
    #1 chk("full_reissue", {mem_req_valid_o, mem_req_addr_o}, {1'b1, 32'h104});
    tick();
    ifu_req_valid_i = 0;
    rsp(32'hBBBB0002);
    tick();
    rsp(32'hCCCC0003);
    tick();
    ifu_req_valid_i = 1; ifu_req_addr_i = 32'h200;
    tick();
    ifu_req_addr_i = 32'h204;
    tick();
    ifu_req_valid_i = 0;
    flush_i = 1;
    tick();
    rsp(32'hDEAD0001);
    #1 chk("flush_rsp0", {ifu_rsp_valid_o, ifu_rsp_rdata_o}, '0);
    tick();
    rsp(32'hDEAD0002);
    #1 chk("flush_rsp1", {ifu_rsp_valid_o, ifu_rsp_rdata_o}, '0);
    tick();
    set_lsu(1, 32'h40, 0, 0, 4'hF);
    tick();
    lsu_req_valid_i = 0;
    rsp(32'h12345678);
    #1 chk("load_rsp", {lsu_rsp_valid_o, lsu_rsp_rdata_o}, {1'b1, 32'h12345678});
    tick();
    set_lsu(1, 32'h80, 1, 32'hCAFEF00D, 4'b0011);
    #1 chk("store_req", {mem_req_valid_o, mem_req_addr_o, mem_req_we_o, mem_req_wdata_o, mem_req_be_o},
           {1'b1, 32'h80, 1'b1, 32'hCAFEF00D, 4'b0011});
    tick();
    set_lsu(0, 0, 0, 0, 0);
    rsp(32'h0);
    #1 chk("store_rsp", {lsu_rsp_valid_o, ifu_rsp_valid_o}, 2'b10);
    tick();
    ifu_req_valid_i = 1; ifu_req_addr_i = 32'h300;
    tick();
    ifu_req_valid_i = 0;
    set_lsu(1, 32'h400, 0, 0, 4'hF);
    tick();
    rst_ni = 0; ifu_req_valid_i = 1;
    rsp(32'h77);
    #1 chk("rst_mid", {mem_req_valid_o, ifu_req_ready_o, lsu_req_ready_o, ifu_rsp_valid_o, lsu_rsp_valid_o,
                       mem_req_addr_o}, '0);
    tick();
    rst_ni = 1; ifu_req_valid_i = 0; lsu_req_valid_i = 0;
    rsp(32'h55);
    #1 chk("stray_rsp", {ifu_rsp_valid_o, lsu_rsp_valid_o}, 2'b00);
    tick();
    for (int c = 0; c < 3000; c++) begin
      if (!ifu_req_valid_i || fire_i) begin
        ifu_req_valid_i = 1'($urandom_range(0, 1));
        ifu_req_addr_i = $urandom & 32'hFFFF_FFFC;
      end
      if (!lsu_req_valid_i || fire_l)
        set_lsu(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom));
      mem_req_ready_i = $urandom_range(0, 9) < 7;
      flush_i = $urandom_range(0, 9) == 0;
      rst_ni = $urandom_range(0, 249) != 0;
      if ($urandom_range(0, 9) < 4) rsp($urandom);
      tick();
    end
    rst_ni = 1; ifu_req_valid_i = 0; lsu_req_valid_i = 0; mem_req_ready_i = 1;
    repeat (6) begin
      rsp($urandom);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
